// File: rtl/fact_regs_if.sv
// CPU-side word bus into the factorial accelerator register block.
// Master drives we/a/wd; slave returns combinational rd.
interface fact_regs_if #(
   parameter int WIDTH = 32
);
   logic             we;
   logic [1:0]       a;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd;

   modport master (
      output we,
      output a,
      output wd,
      input  rd
   );

   modport slave (
      input  we,
      input  a,
      input  wd,
      output rd
   );
endinterface

// File: rtl/fact_regs.sv
// Register front end for the factorial core: operand, GO pulse, sticky status, result.
// Optional FACT_REGS_IRQ_EN adds a registered irq and a write-1 status clear at a=2.
module fact_regs #(
   parameter int WIDTH  = 32,
   parameter int N_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   fact_regs_if.slave       bus,
   output logic [WIDTH-1:0] fact_n,
   output logic             fact_go,
   input  logic             fact_done,
   input  logic             fact_err,
   input  logic [WIDTH-1:0] fact_nf,
`ifdef FACT_REGS_IRQ_EN
   output logic             irq,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [N_BITS-1:0]   n_q, n_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
`ifdef FACT_REGS_IRQ_EN
   logic                irq_q, irq_d;
`endif

   logic wr_n, wr_go, go_acc, in_wait;

   assign wr_n    = bus.we && (bus.a == 2'd0);
   assign wr_go   = bus.we && (bus.a == 2'd1);
   assign go_acc  = wr_go && bus.wd[0] && (state_q == IDLE);
   assign in_wait = (state_q == WAIT);

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      result_d = result_q;
      done_d   = done_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE:    if (go_acc) state_d = PULSE;
         PULSE:   state_d = WAIT;
         WAIT:    if (fact_done || fact_err) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wr_n && !busy_q) n_d = bus.wd[N_BITS-1:0];

      if (go_acc) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end

`ifdef FACT_REGS_IRQ_EN
      if (bus.we && (bus.a == 2'd2) && bus.wd[0]) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
`endif

      // Completion is applied last so it overrides a same-edge status clear.
      if (in_wait && fact_err) begin
         err_d = 1'b1;
      end else if (in_wait && fact_done) begin
         done_d   = 1'b1;
         result_d = fact_nf;
      end

      go_d   = (state_d == PULSE);
      busy_d = (state_d != IDLE);
`ifdef FACT_REGS_IRQ_EN
      irq_d  = done_d | err_d;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         n_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         go_q     <= 1'b0;
         busy_q   <= 1'b0;
`ifdef FACT_REGS_IRQ_EN
         irq_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
         go_q     <= go_d;
         busy_q   <= busy_d;
`ifdef FACT_REGS_IRQ_EN
         irq_q    <= irq_d;
`endif
      end
   end

   always_comb begin
      bus.rd = '0;
      unique case (bus.a)
         2'd0:    bus.rd = WIDTH'(n_q);
         2'd1:    bus.rd = WIDTH'(busy_q);
         2'd2:    bus.rd = WIDTH'({err_q, done_q});
         2'd3:    bus.rd = result_q;
         default: bus.rd = '0;
      endcase
   end

   assign fact_n  = WIDTH'(n_q);
   assign fact_go = go_q;
   assign busy    = busy_q;
`ifdef FACT_REGS_IRQ_EN
   assign irq     = irq_q;
`endif

endmodule
